hazard_sb: RTL and testbench

HAZARD_SB -- requirements
Module: hazard_sb

---
 rtl/hazard_sb.sv | 184 ++++++++++++++++++
 tb/tb_hazard_sb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
// hazard_sb: pipeline hazard unit -- operand forwarding, load-use/branch stalls, flushes and
// an optional multicycle div/mul busy tracker built only when HAZARD_MULTICYCLE_EN is defined.
module hazard_sb #(
   parameter int REG_AW     = 5,
   parameter int DIV_CYCLES = 32,
   parameter int MUL_CYCLES = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [REG_AW-1:0] rsD,
   input  logic [REG_AW-1:0] rtD,
   input  logic              branchD,
   input  logic [REG_AW-1:0] rsE,
   input  logic [REG_AW-1:0] rtE,
   input  logic [REG_AW-1:0] writeregE,
   input  logic [REG_AW-1:0] writeregM,
   input  logic [REG_AW-1:0] writeregW,
   input  logic              regwriteE,
   input  logic              regwriteM,
   input  logic              regwriteW,
   input  logic              memtoregE,
   input  logic              memtoregM,
   input  logic              divstartE,
   input  logic              mulstartE,
   input  logic              flush_req,
   output logic [1:0]        forwardaE,
   output logic [1:0]        forwardbE,
   output logic              forwardaD,
   output logic              forwardbD,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              flushD,
   output logic              flushE,
   output logic              mdbusy,
   output logic              md_done
);

   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

   if ((DIV_CYCLES < 2) || (MUL_CYCLES < 2)) begin : g_cfg_check
      $error("hazard_sb: DIV_CYCLES and MUL_CYCLES must be at least 2");
   end

   // Register 0 is hardwired, so it never forwards; the ME stage is younger and wins over WB.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic [REG_AW-1:0] wr_m,
      input logic              we_m,
      input logic [REG_AW-1:0] wr_w,
      input logic              we_w
   );
      logic [1:0] sel;
      if ((src != REG_ZERO) && (src == wr_m) && we_m) begin
         sel = 2'b10;
      end else if ((src != REG_ZERO) && (src == wr_w) && we_w) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   function automatic logic dest_hits(
      input logic [REG_AW-1:0] dst,
      input logic [REG_AW-1:0] src_a,
      input logic [REG_AW-1:0] src_b
   );
      return (dst != REG_ZERO) && ((dst == src_a) || (dst == src_b));
   endfunction

   logic lwstall_s;
   logic branchstall_s;
   logic mdstall_s;

   // Forwarding selects and the single-cycle pipeline hazards.
   always_comb begin
      forwardaE     = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
      forwardbE     = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
      forwardaD     = (rsD != REG_ZERO) && (rsD == writeregM) && regwriteM;
      forwardbD     = (rtD != REG_ZERO) && (rtD == writeregM) && regwriteM;
      lwstall_s     = memtoregE && dest_hits(writeregE, rsD, rtD);
      branchstall_s = branchD && ((regwriteE && dest_hits(writeregE, rsD, rtD)) ||
                                  (memtoregM && dest_hits(writeregM, rsD, rtD)));
   end

`ifdef HAZARD_MULTICYCLE_EN
   localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_e;

   md_state_e        md_state_q;
   md_state_e        md_state_d;
   logic [CNT_W-1:0] md_cnt_q;
   logic [CNT_W-1:0] md_cnt_d;

   // Multicycle state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         md_state_q <= IDLE;
         md_cnt_q   <= CNT_ZERO;
      end else begin
         md_state_q <= md_state_d;
         md_cnt_q   <= md_cnt_d;
      end
   end

   // Next state: a flush aborts any operation without ever reaching DONE.
   always_comb begin
      md_state_d = md_state_q;
      md_cnt_d   = md_cnt_q;
      mdstall_s  = 1'b0;
      if (flush_req) begin
         md_state_d = IDLE;
         md_cnt_d   = CNT_ZERO;
      end else begin
         case (md_state_q)
            IDLE: begin
               if (divstartE) begin
                  md_state_d = BUSY;
                  md_cnt_d   = DIV_LOAD;
               end else if (mulstartE) begin
                  md_state_d = BUSY;
                  md_cnt_d   = MUL_LOAD;
               end else begin
                  md_state_d = IDLE;
               end
            end
            BUSY: begin
               md_cnt_d = md_cnt_q - CNT_ONE;
               if (md_cnt_q == CNT_ONE) begin
                  md_state_d = DONE;
               end else begin
                  md_state_d = BUSY;
               end
            end
            DONE: begin
               md_state_d = IDLE;
               md_cnt_d   = CNT_ZERO;
            end
            default: begin
               md_state_d = IDLE;
               md_cnt_d   = CNT_ZERO;
            end
         endcase
      end
      // Stall starts in the very cycle the start is seen, before BUSY is entered.
      case (md_state_q)
         IDLE:    mdstall_s = divstartE | mulstartE;
         BUSY:    mdstall_s = 1'b1;
         DONE:    mdstall_s = 1'b0;
         default: mdstall_s = 1'b0;
      endcase
   end

   assign mdbusy  = (md_state_q == BUSY);
   assign md_done = (md_state_q == DONE);
`else
   logic md_unused;
   assign md_unused = ^{clk, resetn, divstartE, mulstartE};
   assign mdstall_s = 1'b0;
   assign mdbusy    = 1'b0;
   assign md_done   = 1'b0;
`endif

   // Stall/flush combination; a flush request overrides every stall.
   always_comb begin
      stallE = mdstall_s & ~flush_req;
      stallD = (lwstall_s | branchstall_s | mdstall_s) & ~flush_req;
      stallF = stallD;
      flushE = flush_req | ((lwstall_s | branchstall_s) & ~mdstall_s);
      flushD = flush_req;
   end

endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb: a stimulus process pushes expected outputs from a timeline
// model of the multicycle unit, and a monitor pops and compares them on every falling edge.
module tb_hazard_sb;
   localparam int AW   = 5;
   localparam int DIVN = 8;
   localparam int MULN = 4;
`ifdef HAZARD_MULTICYCLE_EN
   localparam bit MC_EN = 1'b1;
`else
   localparam bit MC_EN = 1'b0;
`endif
   localparam int M_IDLE = 0;
   localparam int M_BUSY = 1;
   localparam int M_DONE = 2;

   typedef struct {
      logic          rstn;
      logic [AW-1:0] rsD, rtD, rsE, rtE, wE, wM, wW;
      logic          brD, rwE, rwM, rwW, memE, memM, div, mul, flush;
   } stim_t;

   typedef struct {
      int         cyc;
      logic [1:0] fa, fb;
      logic       fad, fbd, sf, sd, se, fd, fe, busy, done;
   } exp_t;

   logic          clk = 1'b0;
   logic          resetn;
   logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic          branchD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
   logic          divstartE, mulstartE, flush_req;
   logic [1:0]    forwardaE, forwardbE;
   logic          forwardaD, forwardbD, stallF, stallD, stallE, flushD, flushE, mdbusy, md_done;

   int    checks;
   int    failures;
   bit    act_m;
   int    start_m;
   int    len_m;
   int    cyc_m;
   stim_t prev_s;
   exp_t  exp_q[$];

   always #5 clk = ~clk;

   hazard_sb #(.REG_AW(AW), .DIV_CYCLES(DIVN), .MUL_CYCLES(MULN)) dut (
      .clk(clk), .resetn(resetn),
      .rsD(rsD), .rtD(rtD), .branchD(branchD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .memtoregE(memtoregE), .memtoregM(memtoregM),
      .divstartE(divstartE), .mulstartE(mulstartE), .flush_req(flush_req),
      .forwardaE(forwardaE), .forwardbE(forwardbE), .forwardaD(forwardaD), .forwardbD(forwardbD),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
      .mdbusy(mdbusy), .md_done(md_done)
   );

   function automatic stim_t zero_stim();
      stim_t s;
      s.rstn = 1'b1;
      s.rsD = '0; s.rtD = '0; s.rsE = '0; s.rtE = '0; s.wE = '0; s.wM = '0; s.wW = '0;
      s.brD = 1'b0; s.rwE = 1'b0; s.rwM = 1'b0; s.rwW = 1'b0; s.memE = 1'b0; s.memM = 1'b0;
      s.div = 1'b0; s.mul = 1'b0; s.flush = 1'b0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rstn  = ($urandom_range(0, 199) != 0);
      s.rsD   = AW'($urandom_range(0, 3));
      s.rtD   = AW'($urandom_range(0, 3));
      s.rsE   = AW'($urandom_range(0, 3));
      s.rtE   = AW'($urandom_range(0, 3));
      s.wE    = AW'($urandom_range(0, 3));
      s.wM    = AW'($urandom_range(0, 3));
      s.wW    = AW'($urandom_range(0, 3));
      s.brD   = 1'($urandom_range(0, 1));
      s.rwE   = 1'($urandom_range(0, 1));
      s.rwM   = 1'($urandom_range(0, 1));
      s.rwW   = 1'($urandom_range(0, 1));
      s.memE  = 1'($urandom_range(0, 1));
      s.memM  = 1'($urandom_range(0, 1));
      s.div   = ($urandom_range(0, 7) == 0);
      s.mul   = ($urandom_range(0, 7) == 0);
      s.flush = ($urandom_range(0, 15) == 0);
      return s;
   endfunction

   // Operation occupies cycles start..start+len: start cycle is IDLE, then BUSY, last is DONE.
   function automatic int state_of(int c);
      if (!act_m || (c <= start_m) || (c > start_m + len_m)) return M_IDLE;
      else if (c == start_m + len_m) return M_DONE;
      else return M_BUSY;
   endfunction

   function automatic logic [1:0] fwd_ex(logic [AW-1:0] src, stim_t s);
      if (src != '0 && src == s.wM && s.rwM) return 2'b10;
      else if (src != '0 && src == s.wW && s.rwW) return 2'b01;
      else return 2'b00;
   endfunction

   function automatic bit hits(logic [AW-1:0] w, logic [AW-1:0] a, logic [AW-1:0] b);
      return (w != '0) && (w == a || w == b);
   endfunction

   function automatic exp_t expect_of(stim_t s, int st);
      exp_t e;
      bit   lw, br, md;
      lw     = s.memE && hits(s.wE, s.rsD, s.rtD);
      br     = s.brD && ((s.rwE && hits(s.wE, s.rsD, s.rtD)) || (s.memM && hits(s.wM, s.rsD, s.rtD)));
      md     = MC_EN && (st == M_BUSY || (st == M_IDLE && (s.div || s.mul)));
      e.cyc  = cyc_m;
      e.fa   = fwd_ex(s.rsE, s);
      e.fb   = fwd_ex(s.rtE, s);
      e.fad  = (s.rsD != '0) && (s.rsD == s.wM) && s.rwM;
      e.fbd  = (s.rtD != '0) && (s.rtD == s.wM) && s.rwM;
      e.se   = md && !s.flush;
      e.sd   = (lw || br || md) && !s.flush;
      e.sf   = e.sd;
      e.fe   = s.flush || ((lw || br) && !md);
      e.fd   = s.flush;
      e.busy = (st == M_BUSY);
      e.done = (st == M_DONE);
      return e;
   endfunction

   task automatic drive(input stim_t s);
      resetn = s.rstn;
      rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
      writeregE = s.wE; writeregM = s.wM; writeregW = s.wW;
      branchD = s.brD; regwriteE = s.rwE; regwriteM = s.rwM; regwriteW = s.rwW;
      memtoregE = s.memE; memtoregM = s.memM;
      divstartE = s.div; mulstartE = s.mul; flush_req = s.flush;
   endtask

   task automatic apply(input stim_t s);
      int st;
      @(posedge clk);
      #1;
      st = state_of(cyc_m);
      if (!prev_s.rstn || prev_s.flush) begin
         act_m = 1'b0;
      end else if (MC_EN && st == M_IDLE && (prev_s.div || prev_s.mul)) begin
         act_m   = 1'b1;
         start_m = cyc_m;
         len_m   = prev_s.div ? DIVN : MULN;
      end
      cyc_m++;
      if (!s.rstn) act_m = 1'b0;
      drive(s);
      prev_s = s;
      exp_q.push_back(expect_of(s, state_of(cyc_m)));
   endtask

   task automatic chk(string name, int cyc, logic [1:0] got, logic [1:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
      end
   endtask

   // Monitor: outputs are combinational, so one expectation is due every cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("forwardaE", e.cyc, forwardaE, e.fa);
            chk("forwardbE", e.cyc, forwardbE, e.fb);
            chk("forwardaD", e.cyc, {1'b0, forwardaD}, {1'b0, e.fad});
            chk("forwardbD", e.cyc, {1'b0, forwardbD}, {1'b0, e.fbd});
            chk("stallF",    e.cyc, {1'b0, stallF},    {1'b0, e.sf});
            chk("stallD",    e.cyc, {1'b0, stallD},    {1'b0, e.sd});
            chk("stallE",    e.cyc, {1'b0, stallE},    {1'b0, e.se});
            chk("flushD",    e.cyc, {1'b0, flushD},    {1'b0, e.fd});
            chk("flushE",    e.cyc, {1'b0, flushE},    {1'b0, e.fe});
            chk("mdbusy",    e.cyc, {1'b0, mdbusy},    {1'b0, e.busy});
            chk("md_done",   e.cyc, {1'b0, md_done},   {1'b0, e.done});
         end
      end
   end

   initial begin
      stim_t s;
      checks   = 0;
      failures = 0;
      act_m    = 1'b0;
      start_m  = 0;
      len_m    = 0;
      cyc_m    = 0;
      prev_s   = zero_stim();
      prev_s.rstn = 1'b0;
      drive(prev_s);

      s = zero_stim(); s.rstn = 1'b0;
      apply(s); apply(s);
      s = zero_stim();
      apply(s);

      // Forwarding priority and register-0 exclusion.
      s.rsE = 5'd3; s.wM = 5'd3; s.rwM = 1'b1; s.wW = 5'd3; s.rwW = 1'b1;
      apply(s);
      s.rsE = 5'd0; apply(s);
      s.rsE = 5'd3; s.rtE = 5'd3; s.rwM = 1'b0; apply(s);
      s.rsD = 5'd3; s.rwM = 1'b1; apply(s);

      // Load-use and branch hazards.
      s = zero_stim(); s.memE = 1'b1; s.wE = 5'd5; s.rtD = 5'd5;
      apply(s);
      s.wE = 5'd0; apply(s);
      s = zero_stim(); s.brD = 1'b1; s.rwE = 1'b1; s.wE = 5'd7; s.rsD = 5'd7;
      apply(s);
      s = zero_stim(); s.brD = 1'b1; s.memM = 1'b1; s.wM = 5'd4; s.rtD = 5'd4;
      apply(s);

      // Divide held, then div+mul together, then multiply alone.
      s = zero_stim(); s.div = 1'b1;
      for (int i = 0; i < DIVN + 3; i++) apply(s);
      s.mul = 1'b1;
      for (int i = 0; i < DIVN + 3; i++) apply(s);
      s = zero_stim();
      apply(s); apply(s);
      s.mul = 1'b1; apply(s);
      s.mul = 1'b0;
      for (int i = 0; i < MULN + 2; i++) apply(s);

      // Flush in the third BUSY cycle while a load-use hazard is also present.
      s = zero_stim(); s.div = 1'b1; apply(s);
      s.div = 1'b0; apply(s); apply(s);
      s.flush = 1'b1; s.memE = 1'b1; s.wE = 5'd2; s.rsD = 5'd2; apply(s);
      s = zero_stim();
      for (int i = 0; i < DIVN + 2; i++) apply(s);

      // Asynchronous reset mid-operation, then a fresh full divide.
      s = zero_stim(); s.div = 1'b1; apply(s);
      s.div = 1'b0; apply(s); apply(s);
      s.rstn = 1'b0; apply(s); apply(s);
      s.rstn = 1'b1; s.div = 1'b1; apply(s);
      s.div = 1'b0;
      for (int i = 0; i < DIVN + 2; i++) apply(s);

      for (int i = 0; i < 1500; i++) apply(rand_stim());

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
